// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-register chain.
// Slot indices name the classic five-stage boundaries; slots past MEM/WB are extra memory stages.
package pipe_pkg;

    localparam int unsigned SLOT_IFID  = 0;
    localparam int unsigned SLOT_IDEX  = 1;
    localparam int unsigned SLOT_EXMEM = 2;
    localparam int unsigned SLOT_MEMWB = 3;

    // Per-slot qualifier bits travelling alongside the register tags.
    typedef struct packed {
        logic rs1_use;
        logic rs2_use;
        logic rd_we;
        logic is_load;
    } slot_flags_t;

    localparam int unsigned FLAGS_W = $bits(slot_flags_t);

    localparam slot_flags_t FLAGS_BUBBLE = '{rs1_use: 1'b0, rs2_use: 1'b0, rd_we: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/pipe_chain_ctrl_slot.sv
// One pipeline slot register: bubble beats load, load beats hold.
// A bubble clears every field so an idle slot never carries stale tags.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic              next_valid,
    input  logic [DATA_W-1:0] next_payload,
    input  logic [RA_W-1:0]   next_rs1,
    input  logic [RA_W-1:0]   next_rs2,
    input  logic [RA_W-1:0]   next_rd,
    input  slot_flags_t       next_flags,
    output logic              valid,
    output logic [DATA_W-1:0] payload,
    output logic [RA_W-1:0]   rs1,
    output logic [RA_W-1:0]   rs2,
    output logic [RA_W-1:0]   rd,
    output slot_flags_t       flags
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            payload <= '0;
            rs1     <= '0;
            rs2     <= '0;
            rd      <= '0;
            flags   <= FLAGS_BUBBLE;
        end else if (bubble) begin
            valid   <= 1'b0;
            payload <= '0;
            rs1     <= '0;
            rs2     <= '0;
            rd      <= '0;
            flags   <= FLAGS_BUBBLE;
        end else if (load) begin
            valid   <= next_valid;
            payload <= next_payload;
            rs1     <= next_rs1;
            rs2     <= next_rs2;
            rd      <= next_rd;
            flags   <= next_flags;
        end
    end

endmodule

// File: rtl/pipe_chain_ctrl.sv
// Parametrised IF/ID..MEM/WB register chain with load-use interlock,
// per-slot flush, EX-operand forwarding-source selection and a stall counter.
module pipe_chain_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned NUM_STAGES     = 4,
    parameter int unsigned RA_W           = 3,
    parameter int unsigned LOAD_RDY_STAGE = 3,
    localparam int unsigned SEL_W         = $clog2(NUM_STAGES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_payload,
    input  logic [RA_W-1:0]              in_rs1,
    input  logic [RA_W-1:0]              in_rs2,
    input  logic [RA_W-1:0]              in_rd,
    input  logic                         in_rs1_use,
    input  logic                         in_rs2_use,
    input  logic                         in_rd_we,
    input  logic                         in_is_load,
    input  logic                         freeze,
    input  logic [NUM_STAGES-1:0]        flush_mask,
    output logic                         in_ready,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic [NUM_STAGES*DATA_W-1:0] stage_payload,
    output logic [NUM_STAGES*RA_W-1:0]   stage_rd,
    output logic [NUM_STAGES-1:0]        stage_rd_we,
    output logic                         load_use_stall,
    output logic                         fwd_a_hit,
    output logic                         fwd_b_hit,
    output logic [SEL_W-1:0]             fwd_a_src,
    output logic [SEL_W-1:0]             fwd_b_src,
    output logic [15:0]                  stall_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [NUM_STAGES-1:0] s_valid;
    logic [DATA_W-1:0]     s_payload [NUM_STAGES];
    logic [RA_W-1:0]       s_rs1     [NUM_STAGES];
    logic [RA_W-1:0]       s_rs2     [NUM_STAGES];
    logic [RA_W-1:0]       s_rd      [NUM_STAGES];
    slot_flags_t           s_flags   [NUM_STAGES];

    logic [NUM_STAGES-1:0] nxt_valid;
    logic [DATA_W-1:0]     nxt_payload [NUM_STAGES];
    logic [RA_W-1:0]       nxt_rs1     [NUM_STAGES];
    logic [RA_W-1:0]       nxt_rs2     [NUM_STAGES];
    logic [RA_W-1:0]       nxt_rd      [NUM_STAGES];
    slot_flags_t           nxt_flags   [NUM_STAGES];

    logic [NUM_STAGES-1:0] slot_load;
    logic [NUM_STAGES-1:0] slot_bubble;

    logic [DATA_W-1:0] entry_payload;
    logic [RA_W-1:0]   entry_rs1;
    logic [RA_W-1:0]   entry_rs2;
    logic [RA_W-1:0]   entry_rd;
    slot_flags_t       entry_flags;

    logic haz_a;
    logic haz_b;

    // An empty fetch enters slot 0 as a clean bubble rather than stray tags.
    always_comb begin
        entry_payload = '0;
        entry_rs1     = '0;
        entry_rs2     = '0;
        entry_rd      = '0;
        entry_flags   = FLAGS_BUBBLE;
        if (in_valid) begin
            entry_payload = in_payload;
            entry_rs1     = in_rs1;
            entry_rs2     = in_rs2;
            entry_rd      = in_rd;
            entry_flags   = '{rs1_use: in_rs1_use, rs2_use: in_rs2_use,
                              rd_we: in_rd_we, is_load: in_is_load};
        end
    end

    // Youngest writer decides; only a not-yet-ready load creates a hazard.
    always_comb begin
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int j = int'(NUM_STAGES) - 1; j >= int'(SLOT_IDEX); j--) begin
            if (s_valid[j] && s_flags[j].rd_we) begin
                if (s_rd[j] == s_rs1[SLOT_IFID]) begin
                    haz_a = s_flags[j].is_load && (j < int'(LOAD_RDY_STAGE) - 1);
                end
                if (s_rd[j] == s_rs2[SLOT_IFID]) begin
                    haz_b = s_flags[j].is_load && (j < int'(LOAD_RDY_STAGE) - 1);
                end
            end
        end
    end

    assign load_use_stall = s_valid[SLOT_IFID] &&
                            ((s_flags[SLOT_IFID].rs1_use && haz_a) ||
                             (s_flags[SLOT_IFID].rs2_use && haz_b));

    assign in_ready = !freeze && !load_use_stall;

    // Forwarding for the ID/EX operands; iterate oldest-first so the youngest match wins.
    always_comb begin
        fwd_a_hit = 1'b0;
        fwd_a_src = '0;
        fwd_b_hit = 1'b0;
        fwd_b_src = '0;
        for (int j = int'(NUM_STAGES) - 1; j >= int'(SLOT_EXMEM); j--) begin
            if (s_valid[SLOT_IDEX] && s_valid[j] && s_flags[j].rd_we) begin
                if (s_flags[SLOT_IDEX].rs1_use && (s_rd[j] == s_rs1[SLOT_IDEX])) begin
                    fwd_a_hit = 1'b1;
                    fwd_a_src = SEL_W'(j);
                end
                if (s_flags[SLOT_IDEX].rs2_use && (s_rd[j] == s_rs2[SLOT_IDEX])) begin
                    fwd_b_hit = 1'b1;
                    fwd_b_src = SEL_W'(j);
                end
            end
        end
    end

    // Freeze holds everything; a stall holds IF/ID and bubbles ID/EX; flush wins over all.
    always_comb begin
        slot_load   = '0;
        slot_bubble = flush_mask;
        if (!freeze) begin
            slot_load = {NUM_STAGES{1'b1}};
            if (load_use_stall) begin
                slot_load[SLOT_IFID]   = 1'b0;
                slot_bubble[SLOT_IDEX] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slot
        if (k == 0) begin : g_entry
            assign nxt_valid[k]   = in_valid;
            assign nxt_payload[k] = entry_payload;
            assign nxt_rs1[k]     = entry_rs1;
            assign nxt_rs2[k]     = entry_rs2;
            assign nxt_rd[k]      = entry_rd;
            assign nxt_flags[k]   = entry_flags;
        end else begin : g_chain
            assign nxt_valid[k]   = s_valid[k-1];
            assign nxt_payload[k] = s_payload[k-1];
            assign nxt_rs1[k]     = s_rs1[k-1];
            assign nxt_rs2[k]     = s_rs2[k-1];
            assign nxt_rd[k]      = s_rd[k-1];
            assign nxt_flags[k]   = s_flags[k-1];
        end

        pipe_slot #(
            .DATA_W (DATA_W),
            .RA_W   (RA_W)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .load         (slot_load[k]),
            .bubble       (slot_bubble[k]),
            .next_valid   (nxt_valid[k]),
            .next_payload (nxt_payload[k]),
            .next_rs1     (nxt_rs1[k]),
            .next_rs2     (nxt_rs2[k]),
            .next_rd      (nxt_rd[k]),
            .next_flags   (nxt_flags[k]),
            .valid        (s_valid[k]),
            .payload      (s_payload[k]),
            .rs1          (s_rs1[k]),
            .rs2          (s_rs2[k]),
            .rd           (s_rd[k]),
            .flags        (s_flags[k])
        );

        assign stage_payload[k*DATA_W +: DATA_W] = s_payload[k];
        assign stage_rd[k*RA_W +: RA_W]          = s_rd[k];
        assign stage_rd_we[k]                    = s_valid[k] && s_flags[k].rd_we;
    end

    assign stage_valid = s_valid;

    // Counts only cycles the interlock actually costs, i.e. not while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (load_use_stall && !freeze && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
